// File: rtl/aer_pkg.sv
// Shared definitions for the AER receive path (and a future transmitter).
package aer_pkg;

    // Default address-event width in bits.
    localparam int ADDR_W_DEF = 5;

    // Width of the accepted-event counter; wraps modulo 2**EVT_CNT_W.
    localparam int EVT_CNT_W = 8;

    // Receiver handshake FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        ACK  = 2'd2
    } aer_state_t;

endpackage

// File: rtl/aer_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level (AER req or ack).
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the asynchronous level through two flops; reset clears both.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/aer_rx.sv
// AER 4-phase receiver: synchronizes req, captures the address once per
// handshake, emits a one-cycle one-hot synapse strobe and counts events.
//
// Handshake: the sender raises req with addr stable; this block raises ack
// (registered) once the address is captured and holds it until the
// synchronized req falls, then drops ack. en only gates acceptance of a new
// event in IDLE; a handshake already under way always completes.
module aer_rx
    import aer_pkg::*;
#(
    parameter  int ADDR_W = ADDR_W_DEF,
    localparam int N_SYN  = 2 ** ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 req,
    input  logic [ADDR_W-1:0]    addr,
    output logic                 ack,
    output logic [ADDR_W-1:0]    syn_addr,
    output logic [N_SYN-1:0]     syn_pulse,
    output logic [EVT_CNT_W-1:0] evt_cnt
);

    // Synchronized request; the FSM never looks at raw req.
    logic req_s;

    // FSM state is kept as a plain named register so checkers can bind to it.
    aer_state_t            state;
    aer_state_t            state_nxt;
    logic                  ack_nxt;
    logic [ADDR_W-1:0]     syn_addr_nxt;
    logic [N_SYN-1:0]      syn_pulse_nxt;
    logic [EVT_CNT_W-1:0]  evt_cnt_nxt;

    sync_2ff u_req_sync (
        .clk (clk),
        .rst (rst),
        .d   (req),
        .q   (req_s)
    );

    // Next-state and next-output logic; the strobe defaults low every cycle.
    always_comb begin
        state_nxt     = state;
        ack_nxt       = ack;
        syn_addr_nxt  = syn_addr;
        syn_pulse_nxt = '0;
        evt_cnt_nxt   = evt_cnt;
        case (state)
            IDLE: begin
                ack_nxt = 1'b0;
                if (en && req_s) begin
                    state_nxt     = CAPT;
                    syn_addr_nxt  = addr;
                    syn_pulse_nxt = {{(N_SYN-1){1'b0}}, 1'b1} << addr;
                end
            end
            CAPT: begin
                state_nxt   = ACK;
                ack_nxt     = 1'b1;
                evt_cnt_nxt = evt_cnt + 1'b1;
            end
            ACK: begin
                ack_nxt = 1'b1;
                if (!req_s) begin
                    state_nxt = IDLE;
                    ack_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                ack_nxt   = 1'b0;
            end
        endcase
    end

    // Register state and all outputs; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ack       <= 1'b0;
            syn_addr  <= '0;
            syn_pulse <= '0;
            evt_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            ack       <= ack_nxt;
            syn_addr  <= syn_addr_nxt;
            syn_pulse <= syn_pulse_nxt;
            evt_cnt   <= evt_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_aer_rx.sv
// Self-checking bench for aer_rx: directed scenarios plus randomized
// handshakes, compared against a cycle-level behavioural model and an
// address scoreboard.
module tb_aer_rx;

    localparam int ADDR_W = 5;
    localparam int N_SYN  = 32;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en  = 1'b0;
    logic              req = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic              ack;
    logic [ADDR_W-1:0] syn_addr;
    logic [N_SYN-1:0]  syn_pulse;
    logic [7:0]        evt_cnt;

    always #5 clk = ~clk;

    aer_rx #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .addr      (addr),
        .ack       (ack),
        .syn_addr  (syn_addr),
        .syn_pulse (syn_pulse),
        .evt_cnt   (evt_cnt)
    );

    // ---------------- checking ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The model sees req two edges late, accepts an event when enabled and
    // idle, acknowledges one cycle after acceptance and releases once the
    // delayed req is seen low. Event count is an integer taken mod 256.
    int   m_phase;        // 0 waiting, 1 just accepted, 2 acknowledging
    bit   m_req_d1, m_req_d2;
    bit   m_ack;
    int   m_addr;
    int   m_pulse_idx;    // -1 when no strobe expected
    int   m_events;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_req_d1 = 0; m_req_d2 = 0; m_ack = 0;
            m_addr = 0; m_pulse_idx = -1; m_events = 0;
        end else begin
            m_pulse_idx = -1;
            if (m_phase == 0) begin
                m_ack = 0;
                if (en && m_req_d2) begin
                    m_phase = 1;
                    m_addr = int'(addr);
                    m_pulse_idx = int'(addr);
                end
            end else if (m_phase == 1) begin
                m_phase = 2;
                m_ack = 1;
                m_events = m_events + 1;
            end else if (!m_req_d2) begin
                m_phase = 0;
                m_ack = 0;
            end
            m_req_d2 = m_req_d1;
            m_req_d1 = req;
        end
    end

    // ---------------- scoreboard ----------------
    logic [ADDR_W-1:0] exp_q[$];
    int  pulse_cnt = 0;
    bit  chk_en = 0;

    // Compare DUT against the model and scoreboard away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] exp_pulse;
            exp_pulse = (m_pulse_idx < 0) ? 32'd0 : (32'd1 << m_pulse_idx);
            check_eq("model_ack", 32'(ack), 32'(m_ack));
            check_eq("model_pulse", syn_pulse, exp_pulse);
            check_eq("model_addr", 32'(syn_addr), 32'(m_addr));
            check_eq("model_cnt", 32'(evt_cnt), 32'(m_events % 256));
            if (syn_pulse != '0) begin
                pulse_cnt++;
                check_eq("pulse_ones", 32'($countones(syn_pulse)), 32'd1);
                if (exp_q.size() == 0) begin
                    check_eq("pulse_unexpected", syn_pulse, 32'd0);
                end else begin
                    logic [ADDR_W-1:0] a;
                    a = exp_q.pop_front();
                    check_eq("pulse_sb", syn_pulse, 32'd1 << a);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = 1'b0; en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        chk_en = 1'b1;
    endtask

    task automatic wait_ack(input logic val, input string tag);
        int n;
        n = 0;
        while (ack !== val && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(ack), 32'(val));
    endtask

    task automatic handshake(input logic [ADDR_W-1:0] a);
        @(negedge clk);
        en = 1'b1; addr = a; req = 1'b1;
        exp_q.push_back(a);
        wait_ack(1'b1, "hs_ack_rise");
        @(negedge clk);
        req = 1'b0;
        wait_ack(1'b0, "hs_ack_fall");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int p0;

        do_reset();
        check_eq("rst_ack", 32'(ack), 32'd0);
        check_eq("rst_pulse", syn_pulse, 32'd0);
        check_eq("rst_addr", 32'(syn_addr), 32'd0);
        check_eq("rst_cnt", 32'(evt_cnt), 32'd0);

        // Single event with exact edge latency.
        @(negedge clk);
        en = 1'b1; addr = 5'd7; req = 1'b1;
        exp_q.push_back(5'd7);
        repeat (3) @(posedge clk);
        #1;
        check_eq("lat_ack_e3", 32'(ack), 32'd0);
        check_eq("lat_pulse_e3", syn_pulse, 32'h0000_0080);
        @(posedge clk); #1;
        check_eq("lat_ack_e4", 32'(ack), 32'd1);
        check_eq("lat_pulse_e4", syn_pulse, 32'd0);
        check_eq("lat_addr", 32'(syn_addr), 32'd7);
        check_eq("lat_cnt", 32'(evt_cnt), 32'd1);
        @(negedge clk);
        req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("lat_fall_e2", 32'(ack), 32'd1);
        @(posedge clk); #1;
        check_eq("lat_fall_e3", 32'(ack), 32'd0);

        // Disabled receiver ignores a pending request.
        do_reset();
        @(negedge clk);
        en = 1'b0; addr = 5'd3; req = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("dis_ack", 32'(ack), 32'd0);
        check_eq("dis_cnt", 32'(evt_cnt), 32'd0);
        en = 1'b1;
        exp_q.push_back(5'd3);
        wait_ack(1'b1, "dis_en_ack");
        check_eq("dis_en_cnt", 32'(evt_cnt), 32'd1);
        req = 1'b0;
        wait_ack(1'b0, "dis_en_fall");

        // Held request yields one event; a re-raise yields a second.
        do_reset();
        p0 = pulse_cnt;
        @(negedge clk);
        en = 1'b1; addr = 5'd12; req = 1'b1;
        exp_q.push_back(5'd12);
        repeat (30) @(negedge clk);
        check_eq("held_pulses", 32'(pulse_cnt - p0), 32'd1);
        check_eq("held_cnt", 32'(evt_cnt), 32'd1);
        req = 1'b0;
        wait_ack(1'b0, "held_fall");
        handshake(5'd20);
        check_eq("held_cnt2", 32'(evt_cnt), 32'd2);

        // 256 back-to-back handshakes wrap the counter.
        do_reset();
        p0 = pulse_cnt;
        for (int i = 0; i < 256; i++) begin
            handshake(ADDR_W'(i % 32));
        end
        check_eq("wrap_cnt", 32'(evt_cnt), 32'd0);
        check_eq("wrap_pulses", 32'(pulse_cnt - p0), 32'd256);
        check_eq("wrap_last_addr", 32'(syn_addr), 32'd31);

        // Reset during ACK, then re-accept the still-high request.
        do_reset();
        @(negedge clk);
        en = 1'b1; addr = 5'd9; req = 1'b1;
        exp_q.push_back(5'd9);
        wait_ack(1'b1, "rstmid_ack");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("rstmid_ack0", 32'(ack), 32'd0);
        check_eq("rstmid_cnt0", 32'(evt_cnt), 32'd0);
        check_eq("rstmid_pulse0", syn_pulse, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back(5'd9);
        wait_ack(1'b1, "rstmid_reacc");
        check_eq("rstmid_cnt1", 32'(evt_cnt), 32'd1);
        req = 1'b0;
        wait_ack(1'b0, "rstmid_fall");

        // en dropped while capturing does not abort the handshake.
        do_reset();
        @(negedge clk);
        en = 1'b1; addr = 5'd17; req = 1'b1;
        exp_q.push_back(5'd17);
        repeat (3) @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        wait_ack(1'b1, "endrop_ack");
        check_eq("endrop_cnt", 32'(evt_cnt), 32'd1);
        req = 1'b0;
        wait_ack(1'b0, "endrop_fall");

        // Randomized handshakes with random enable delays and gaps.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            logic [ADDR_W-1:0] a;
            int pre;
            a = ADDR_W'($urandom_range(0, 31));
            pre = $urandom_range(0, 4);
            @(negedge clk);
            addr = a; req = 1'b1; en = (pre == 0);
            if (pre != 0) begin
                repeat (pre + 2) @(negedge clk);
                en = 1'b1;
            end
            exp_q.push_back(a);
            wait_ack(1'b1, "rnd_ack");
            en = 1'($urandom_range(0, 1));
            addr = ADDR_W'($urandom_range(0, 31));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            req = 1'b0;
            wait_ack(1'b0, "rnd_fall");
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        check_eq("rnd_cnt", 32'(evt_cnt), 32'd40);

        repeat (4) @(negedge clk);
        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aer_rx.md
AER_RX -- requirements
Module: aer_rx

Interface
REQ-001 The parameter ADDR_W SHALL be: ADDR_W, default 5, address-event width in bits.
REQ-002 The parameter N_SYN SHALL be: N_SYN, default 2**ADDR_W, number of decoded synapse lines; derived from ADDR_W and not overridden.
REQ-003 The port clk SHALL be: clk  input  1  single system clock; all state updates on rising edge.
REQ-004 The port rst SHALL be: rst  input  1  synchronous, active-high reset.
REQ-005 The port en SHALL be: en  input  1  receive enable; gates acceptance of new events only.
REQ-006 The port req SHALL be: req  input  1  4-phase AER request from an asynchronous sender.
REQ-007 The port addr SHALL be: addr  input  ADDR_W  event address; stable from req rise until ack rise.
REQ-008 The port ack SHALL be: ack  output  1  4-phase AER acknowledge, registered.
REQ-009 The port syn_addr SHALL be: syn_addr  output  ADDR_W  last accepted address, registered.
REQ-010 The port syn_pulse SHALL be: syn_pulse  output  N_SYN  one-hot synapse strobe, registered, one cycle per event.
REQ-011 The port evt_cnt SHALL be: evt_cnt  output  8  accepted-event count, registered.

Function
REQ-012 req SHALL pass through a 2-flop synchronizer; req_s is req delayed by 2 rising edges; FSM uses only req_s.
REQ-013 FSM states SHALL be IDLE, CAPT, ACK.
REQ-014 IDLE -> CAPT SHALL occur on the edge where en=1 and req_s=1; at that edge syn_addr <= addr and syn_pulse <= one-hot(addr).
REQ-015 IDLE with en=0 or req_s=0 SHALL remain IDLE; ack=0, syn_pulse=0.
REQ-016 CAPT SHALL last exactly one cycle and then move to ACK; at that edge ack <= 1, syn_pulse <= 0, and evt_cnt <= evt_cnt+1 mod 256 (wraps 255 -> 0).
REQ-017 ACK SHALL hold ack=1 while req_s=1; on the edge where req_s=0, the FSM SHALL move to IDLE and ack <= 0.
REQ-018 Latency: ack SHALL rise on the 4th rising edge after req is first sampled high, and fall on the 3rd rising edge after req is first sampled low.
REQ-019 syn_pulse SHALL be high for exactly one cycle per accepted event, with exactly one bit set, at index syn_addr.
REQ-020 en deasserting in CAPT or ACK SHALL NOT abort the handshake; the event completes normally.
REQ-021 req held high continuously SHALL produce exactly one event; a new event requires req_s low and IDLE to be reached first.
REQ-022 Changes on addr outside the IDLE -> CAPT edge SHALL be ignored.

Reset
REQ-023 With rst=1 at a rising edge, the block SHALL set state=IDLE, ack=0, syn_pulse=0, syn_addr=0, evt_cnt=0, and both synchronizer flops to 0.
REQ-024 rst SHALL take priority over all other inputs; reset mid-handshake SHALL drop ack on that edge without issuing a syn_pulse.
REQ-025 After reset release with req still high, the block SHALL accept that request as a new event once it has been re-synchronized (per REQ-018).

Structure
REQ-026 Shared package aer_pkg SHALL hold ADDR_W default, the FSM state type (IDLE, CAPT, ACK), and the evt_cnt width constant.
REQ-027 Synchronizer SHALL be sub-module sync_2ff (1-bit, clk, rst, d, q), reusable by a future AER transmitter for its ack input.

Verification
REQ-028 Single event: reset, en=1, addr=5'd7, req=1 -> ack rises at edge 4; syn_pulse=32'h0000_0080 for one cycle; syn_addr=7; evt_cnt=1; req=0 -> ack=0 at edge 3.
REQ-029 Disabled: en=0, req=1, addr=3 for 20 cycles -> ack=0, syn_pulse=0 and evt_cnt=0 throughout; then en=1 -> event accepted with syn_pulse bit 3.
REQ-030 Held req: req high for 30 cycles -> exactly one syn_pulse and evt_cnt=1; after a low phase and a re-raise, evt_cnt=2.
REQ-031 Wrap: 256 back-to-back handshakes with addr=0..31 cycling -> evt_cnt=0 at the end; each syn_pulse bit matches its addr; addr=31 sets bit 31.
REQ-032 Reset mid-operation: assert rst in ACK -> ack=0 next edge, evt_cnt=0; with req still high after release -> new event, evt_cnt=1.
REQ-033 en drop in CAPT: en=0 on the cycle after req_s rises -> the handshake still completes and evt_cnt increments.
